hangman_datapath: RTL
=====================

// Module: hangman_datapath
// PURPOSE
//  Responder half of the hangman control<->datapath handshake. Executes the
//  control FSM's commands: word load, guess compare, blank fill, body-part draw,
//  gallows load, countdown, game-over clear. Returns the status flags the FSM
//  branches on. Drives VGA pixel x/y/colour; the control FSM owns the VGA plot
//  enable.
// PARAMETERS
//  MAX_LEN     8           max letters in secret word
//  MAX_MISS    6           misses that complete the gallows figure
//  CLK_HZ      50_000_000  clk frequency; one-second tick prescaler
//  TIME_LIMIT  60          seconds of active timecount before timeout
//  CELL        8           letter-cell edge in pixels (square)
// PORTS
//  clk          in   1  system clock
//  resetn       in   1  asynchronous active-low reset
//  ld           in   1  word-load phase enable
//  ld_g         in   1  gallows-load request
//  timecount    in   1  countdown run enable
//  compare      in   1  guess-entry phase enable
//  fill         in   1  reveal/fill request
//  draw         in   1  body-part draw request
//  over         in   1  game-over clear
//  key_load     in   1  keyboard "store letter" key (level, edge-detected here)
//  key_try      in   1  keyboard "submit guess" key (level, edge-detected here)
//  letter_in    in   5  letter code, 1=A..26=Z; 0 and 27-31 invalid
//  timeout      out  1  time limit reached (sticky)
//  graph_loaded out  1  gallows sweep done (sticky)
//  match        out  1  last guess hits an unrevealed letter
//  filled       out  1  fill sweep done
//  finish       out  1  draw sweep done
//  complete     out  1  misses == MAX_MISS
//  cont         out  1  word not fully revealed; drives control "continue"
//  word_len     out  4  letters stored
//  vga_x        out  8  pixel x
//  vga_y        out  7  pixel y
//  vga_colour   out  3  pixel colour
// BEHAVIOUR
//  Reset: all outputs, word RAM, revealed mask, guess, counters = 0; sweeper IDLE.
//  Rising edges of key_load/key_try are detected with one flop each (edge = now&~prev).
//  Word load: key_load edge while ld=1, letter valid, word_len<MAX_LEN ->
//  word[word_len]<=letter_in, word_len++.
//   - Full, or invalid letter: ignored, no state change.
//  Guess: key_try edge while compare=1, letter valid -> guess_r<=letter_in.
//   - hit[i] = used[i] & (word[i]==guess_r).
//   - match = |(hit & ~revealed), combinational from guess_r. Valid the cycle
//     after the strobe; held until the next guess.
//   - Repeating an already revealed letter is a miss.
//  Sweeper FSM: IDLE -> SWEEP_G | SWEEP_F | SWEEP_D -> DONE -> IDLE.
//   - Start on rising edge of ld_g / fill / draw. Priority ld_g > fill > draw.
//     A request arriving while not IDLE is ignored.
//   - Sweep walks x fastest, then y, over a WxH box. It emits one pixel per cycle
//     and enters DONE after W*H cycles.
//   - DONE holds until the request input falls. Any request input is 0 -> IDLE.
//  SWEEP_G: gallows box from pkg origin/size.
//   - graph_loaded sets on entering DONE and stays 1 until over.
//  SWEEP_F: at start cycle, revealed |= hit. Box is MAX_LEN cells in a row,
//   CELL x CELL each; colour is white if revealed[cell] else black.
//   - filled=1 while in DONE.
//   - cont = ((revealed&used)!=used), stable while filled=1.
//  SWEEP_D: at start cycle, misses++ (saturates at MAX_MISS). Box is the
//   pkg part table entry for the new misses value; colour red.
//   - finish=1 while in DONE. complete = (misses==MAX_MISS).
//  Timer: prescaler counts while timecount=1 and pauses, not clears, when 0.
//   - Each CLK_HZ cycles, secs++.
//   - timeout sets when secs==TIME_LIMIT and stays 1 until over.
//  over=1: synchronous clear of word, used, word_len, revealed, guess, misses,
//   prescaler, secs, and the sticky flags; sweeper -> IDLE.
//   - over has priority over every same-cycle operation.
//  Empty word (word_len=0): every guess misses; cont=0.
//  Outside sweeps: vga_x/vga_y/vga_colour hold last value.
// STRUCTURE
//  hangman_pkg: letter code range, colour constants, gallows origin/size,
//   part box table [1..MAX_MISS] (x,y,w,h), sweeper state encoding.
//  Sub-module box_sweeper: start/origin/size in; x,y,active,done out.
//   Instantiated once; the three sweep types are muxed into it.
// TESTING
//  1. Load C,A,T (codes 3,1,20) via key_load pulses -> word_len=3; 9th key with
//     MAX_LEN=8 full -> ignored.
//  2. Guess A (1) with compare=1 -> match=1 the next cycle. Fill -> filled after
//     3*... MAX_LEN*CELL*CELL cycles, cont=1. Guess A again -> match=0.
//  3. Six wrong guesses each followed by draw -> finish each time; complete=1
//     after 6th; 7th draw keeps misses=6.
//  4. Reveal C,A,T -> after final fill, filled=1 and cont=0.
//  5. CLK_HZ=4, TIME_LIMIT=2, timecount=1 for 8 cycles -> timeout=1. With
//     timecount toggling, timeout needs 8 enabled cycles. over -> timeout=0.
//  6. resetn low mid-SWEEP_D -> all outputs 0 immediately; sweeper IDLE.
//     over same cycle as key_load -> word_len=0.

Source files
------------

// File: rtl/hangman_pkg.sv
// Hangman datapath shared types and constants.
// Letter codes, colours, sweep boxes and sweeper states.
package hangman_pkg;

  localparam logic [4:0] LET_MIN = 5'd1;
  localparam logic [4:0] LET_MAX = 5'd26;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
  } box_t;

  localparam box_t GAL_BOX = '{
    x: 8'd20, y: 7'd10, w: 8'd4, h: 7'd30
  };

  localparam logic [7:0] FILL_X0 = 8'd0;
  localparam logic [6:0] FILL_Y0 = 7'd100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP_G,
    S_SWEEP_F,
    S_SWEEP_D,
    S_DONE
  } sweep_st_t;

  typedef enum logic [1:0] {
    K_G,
    K_F,
    K_D
  } sweep_kind_t;

  function automatic logic letter_ok(
    input logic [4:0] l
  );
    return (l >= LET_MIN) && (l <= LET_MAX);
  endfunction

  // Body part boxes, indexed by miss count 1..6
  function automatic box_t part_box(
    input logic [2:0] m
  );
    box_t b;
    case (m)
      3'd1:    b = '{x: 8'd40, y: 7'd20, w: 8'd4, h: 7'd4};
      3'd2:    b = '{x: 8'd41, y: 7'd24, w: 8'd2, h: 7'd6};
      3'd3:    b = '{x: 8'd38, y: 7'd25, w: 8'd3, h: 7'd2};
      3'd4:    b = '{x: 8'd43, y: 7'd25, w: 8'd3, h: 7'd2};
      3'd5:    b = '{x: 8'd39, y: 7'd30, w: 8'd2, h: 7'd4};
      3'd6:    b = '{x: 8'd43, y: 7'd30, w: 8'd2, h: 7'd4};
      default: b = '{x: 8'd0,  y: 7'd0,  w: 8'd1, h: 7'd1};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/hangman_if.sv
// Control <-> datapath command/status bundle.
// Control side is master, datapath is slave.
interface hangman_if;
  logic       ld;
  logic       ld_g;
  logic       timecount;
  logic       compare;
  logic       fill;
  logic       draw;
  logic       over;
  logic       key_load;
  logic       key_try;
  logic [4:0] letter_in;
  logic       timeout;
  logic       graph_loaded;
  logic       match;
  logic       filled;
  logic       finish;
  logic       complete;
  logic       cont;
  logic [3:0] word_len;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  modport master (
    output ld, ld_g, timecount, compare,
    output fill, draw, over,
    output key_load, key_try, letter_in,
    input  timeout, graph_loaded, match,
    input  filled, finish, complete, cont,
    input  word_len, vga_x, vga_y, vga_colour
  );

  modport slave (
    input  ld, ld_g, timecount, compare,
    input  fill, draw, over,
    input  key_load, key_try, letter_in,
    output timeout, graph_loaded, match,
    output filled, finish, complete, cont,
    output word_len, vga_x, vga_y, vga_colour
  );
endinterface

// File: rtl/hangman_box_sweeper.sv
// Walks a latched WxH box, x fastest, one pixel
// per cycle; done marks the last pixel cycle.
module hangman_box_sweeper
  import hangman_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       clr,
  input  box_t       box,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       active,
  output logic       done
);

  box_t       b_q;
  logic [7:0] cx;
  logic [6:0] cy;
  logic       x_end;

  assign x     = b_q.x + cx;
  assign y     = b_q.y + cy;
  assign x_end = (cx == b_q.w - 8'd1);
  assign done  = active && x_end
               && (cy == b_q.h - 7'd1);

  // Latch the box on start, then step x then y
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      b_q    <= '0;
      cx     <= '0;
      cy     <= '0;
      active <= 1'b0;
    end else if (clr) begin
      cx     <= '0;
      cy     <= '0;
      active <= 1'b0;
    end else if (start) begin
      b_q    <= box;
      cx     <= '0;
      cy     <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else if (x_end) begin
        cx <= '0;
        cy <= cy + 7'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

endmodule

// File: rtl/hangman_datapath.sv
// Hangman datapath: word store, guess compare,
// reveal mask, miss count, timer and VGA sweeps.
module hangman_datapath
  import hangman_pkg::*;
#(
  parameter int MAX_LEN    = 8,
  parameter int MAX_MISS   = 6,
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIME_LIMIT = 60,
  parameter int CELL       = 8
) (
  input logic      clk,
  input logic      resetn,
  hangman_if.slave ctl
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int PW =
    (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = $clog2(TIME_LIMIT + 1);

  localparam box_t FILL_BOX = '{
    x: FILL_X0,
    y: FILL_Y0,
    w: 8'(MAX_LEN * CELL),
    h: 7'(CELL)
  };

  logic kl_q, kt_q, lg_q, fl_q, dr_q;
  logic kl_rise, kt_rise;

  logic [MAX_LEN-1:0][4:0] word_q;
  logic [MAX_LEN-1:0]      used_q;
  logic [MAX_LEN-1:0]      rev_q;
  logic [MAX_LEN-1:0]      hit;
  logic [3:0]              len_q;
  logic [4:0]              guess_q;
  logic [2:0]              miss_q;
  logic [2:0]              miss_nx;
  logic [PW-1:0]           pre_q;
  logic [SW-1:0]           sec_q;
  logic                    tout_q;
  logic                    gl_q;

  sweep_st_t   st_q, st_d;
  sweep_kind_t kind_q, kind_d;
  logic        idle;
  logic        start_g, start_f, start_d;
  logic        req;
  logic        sw_start, sw_active, sw_done;
  box_t        sw_box;
  logic [7:0]  sw_x;
  logic [6:0]  sw_y;

  logic [7:0] rel;
  logic       pix_rev;
  logic [2:0] pix_col;
  logic [7:0] vx_q;
  logic [6:0] vy_q;
  logic [2:0] vc_q;

  assign kl_rise = ctl.key_load & ~kl_q;
  assign kt_rise = ctl.key_try & ~kt_q;

  assign idle    = (st_q == S_IDLE) & ~ctl.over;
  assign start_g = idle & ctl.ld_g & ~lg_q;
  assign start_f = idle & ctl.fill & ~fl_q
                 & ~start_g;
  assign start_d = idle & ctl.draw & ~dr_q
                 & ~start_g & ~start_f;

  assign miss_nx = (miss_q == 3'(MAX_MISS))
                 ? miss_q : miss_q + 3'd1;

  // Request edge detectors
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kl_q <= 1'b0;
      kt_q <= 1'b0;
      lg_q <= 1'b0;
      fl_q <= 1'b0;
      dr_q <= 1'b0;
    end else begin
      kl_q <= ctl.key_load;
      kt_q <= ctl.key_try;
      lg_q <= ctl.ld_g;
      fl_q <= ctl.fill;
      dr_q <= ctl.draw;
    end
  end

  // Per-letter hits of the held guess
  always_comb begin
    hit = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      hit[i] = used_q[i]
             && (word_q[i] == guess_q);
    end
  end

  // Game state: word, guess, reveal, misses, timer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_q  <= '0;
      used_q  <= '0;
      rev_q   <= '0;
      len_q   <= '0;
      guess_q <= '0;
      miss_q  <= '0;
      pre_q   <= '0;
      sec_q   <= '0;
      tout_q  <= 1'b0;
      gl_q    <= 1'b0;
    end else if (ctl.over) begin
      word_q  <= '0;
      used_q  <= '0;
      rev_q   <= '0;
      len_q   <= '0;
      guess_q <= '0;
      miss_q  <= '0;
      pre_q   <= '0;
      sec_q   <= '0;
      tout_q  <= 1'b0;
      gl_q    <= 1'b0;
    end else begin
      if (ctl.ld && kl_rise
          && letter_ok(ctl.letter_in)
          && (len_q < 4'(MAX_LEN))) begin
        word_q[len_q[IW-1:0]] <= ctl.letter_in;
        used_q[len_q[IW-1:0]] <= 1'b1;
        len_q <= len_q + 4'd1;
      end
      if (ctl.compare && kt_rise
          && letter_ok(ctl.letter_in)) begin
        guess_q <= ctl.letter_in;
      end
      if (start_f) begin
        rev_q <= rev_q | hit;
      end
      if (start_d) begin
        miss_q <= miss_nx;
      end
      if ((st_q == S_SWEEP_G) && sw_done) begin
        gl_q <= 1'b1;
      end
      if (ctl.timecount && !tout_q) begin
        if (pre_q == PW'(CLK_HZ - 1)) begin
          pre_q <= '0;
          sec_q <= sec_q + SW'(1);
          if (sec_q == SW'(TIME_LIMIT - 1)) begin
            tout_q <= 1'b1;
          end
        end else begin
          pre_q <= pre_q + PW'(1);
        end
      end
    end
  end

  // Request line that holds the current DONE
  always_comb begin
    req = 1'b0;
    unique case (kind_q)
      K_G:     req = ctl.ld_g;
      K_F:     req = ctl.fill;
      K_D:     req = ctl.draw;
      default: req = 1'b0;
    endcase
  end

  // Sweeper next state and box select
  always_comb begin
    st_d     = st_q;
    kind_d   = kind_q;
    sw_start = 1'b0;
    sw_box   = GAL_BOX;
    unique case (st_q)
      S_IDLE: begin
        unique case (1'b1)
          start_g: begin
            st_d     = S_SWEEP_G;
            kind_d   = K_G;
            sw_start = 1'b1;
          end
          start_f: begin
            st_d     = S_SWEEP_F;
            kind_d   = K_F;
            sw_start = 1'b1;
            sw_box   = FILL_BOX;
          end
          start_d: begin
            st_d     = S_SWEEP_D;
            kind_d   = K_D;
            sw_start = 1'b1;
            sw_box   = part_box(miss_nx);
          end
          default: ;
        endcase
      end
      S_SWEEP_G, S_SWEEP_F, S_SWEEP_D: begin
        if (sw_done) st_d = S_DONE;
      end
      S_DONE: begin
        if (!req) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    if (ctl.over) st_d = S_IDLE;
  end

  // Sweeper state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= S_IDLE;
      kind_q <= K_G;
    end else begin
      st_q   <= st_d;
      kind_q <= kind_d;
    end
  end

  hangman_box_sweeper u_sweep (
    .clk    (clk),
    .resetn (resetn),
    .start  (sw_start),
    .clr    (ctl.over),
    .box    (sw_box),
    .x      (sw_x),
    .y      (sw_y),
    .active (sw_active),
    .done   (sw_done)
  );

  // Pixel colour for the current sweep
  always_comb begin
    rel     = sw_x - FILL_X0;
    pix_rev = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rel / 8'(CELL) == 8'(i)) begin
        pix_rev = rev_q[i];
      end
    end
    pix_col = COL_WHITE;
    unique case (st_q)
      S_SWEEP_F:
        pix_col = pix_rev ? COL_WHITE : COL_BLACK;
      S_SWEEP_D:
        pix_col = COL_RED;
      default: ;
    endcase
  end

  // VGA pixel registers, held between sweeps
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vx_q <= '0;
      vy_q <= '0;
      vc_q <= '0;
    end else if (sw_active) begin
      vx_q <= sw_x;
      vy_q <= sw_y;
      vc_q <= pix_col;
    end
  end

  assign ctl.timeout      = tout_q;
  assign ctl.graph_loaded = gl_q;
  assign ctl.match        = |(hit & ~rev_q);
  assign ctl.filled       = (st_q == S_DONE)
                          && (kind_q == K_F);
  assign ctl.finish       = (st_q == S_DONE)
                          && (kind_q == K_D);
  assign ctl.complete     = (miss_q == 3'(MAX_MISS));
  assign ctl.cont         = (rev_q & used_q) != used_q;
  assign ctl.word_len     = len_q;
  assign ctl.vga_x        = vx_q;
  assign ctl.vga_y        = vy_q;
  assign ctl.vga_colour   = vc_q;

endmodule
